sys_array_seq_ctrl: RTL and testbench
=====================================

// Module: sys_array_seq_ctrl
// PURPOSE
//  Sequencer for the 2x2 systolic matrix-multiply array. Accepts two packed 2x2 operand matrices
//  through a start/ready handshake and drives the array's row/col inputs with skewed data while
//  holding load_in high. It then waits for the array's done, captures the four 64-bit results and
//  carries, and presents them on a valid/ready output port. Sits between the host/DMA side and the array.
// PARAMETERS
//  DATA_W       32   operand element width (array row/col port width)
//  TIMEOUT_CYC  64   max cycles in WAIT for array done before abort (>=2)
// PORTS
//  clk            in   1         clock, all logic rising-edge
//  rst            in   1         asynchronous reset, active-low
//  start          in   1         request: operands valid this cycle
//  ready          out  1         controller idle, start accepted when start&ready
//  a_mat          in   4*DATA_W  {A11,A10,A01,A00}, A00 in LSBs
//  b_mat          in   4*DATA_W  {B11,B10,B01,B00}, B00 in LSBs
//  load_in        out  1         to array: feed phase active
//  row_in_row0    out  DATA_W    to array row 0
//  row_in_row1    out  DATA_W    to array row 1
//  col_in_col0    out  DATA_W    to array col 0
//  col_in_col1    out  DATA_W    to array col 1
//  arr_done       in   1         from array done
//  arr_result     in   4*64      {r11,r10,r01,r00} from array result_rowXY
//  arr_carry      in   4         {c11,c10,c01,c00} from array carry_XY
//  res_valid      out  1         result held and valid
//  res_ready      in   1         consumer accepts result
//  res_data       out  4*64      captured results, same packing as arr_result
//  res_carry      out  4         captured carries
//  timeout_err    out  1         one-cycle pulse on WAIT timeout
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; ready=1; load_in=0; row/col outs=0; res_valid=0;
//    res_data=0; res_carry=0; timeout_err=0; timeout counter=0. Reset mid-operation aborts silently.
//  - All outputs registered. States: IDLE, FEED0, FEED1, FEED2, WAIT, HOLD.
//  - IDLE: ready=1. start&ready at edge T -> latch a_mat/b_mat, ready=0, FEED0 from T+1.
//  - Feed schedule (load_in=1 in all three cycles):
//      FEED0: row0=A00 row1=0   col0=B00 col1=0
//      FEED1: row0=A01 row1=A10 col0=B10 col1=B01
//      FEED2: row0=0   row1=A11 col0=0   col1=B11
//    Then WAIT: load_in=0, row/col outs=0, counter cleared.
//  - WAIT: counter increments each cycle. On arr_done=1, capture arr_result/arr_carry, go to
//    HOLD with res_valid=1 next cycle. If counter reaches TIMEOUT_CYC-1 without done: pulse
//    timeout_err one cycle, go to IDLE, res_valid stays 0. If done arrives in the same cycle
//    as the timeout, done wins.
//  - arr_done outside WAIT is ignored (no capture, no state change).
//  - HOLD: res_valid=1, res_data/res_carry stable until res_valid&res_ready. On handshake:
//    res_valid=0, go to IDLE, ready=1 next cycle. Results are never overwritten while valid.
//  - start while ready=0 is ignored (not queued). Operand inputs may change after acceptance.
//  - Minimum start-to-start: 3 feed + >=1 WAIT + >=1 HOLD + 1 IDLE cycles.
//  - Width rules: results and carries pass through unmodified; no arithmetic in this block.
// TESTING
//  1 Reset: rst=0 mid-FEED1 -> all outputs 0 immediately, ready=1, load_in=0 after release.
//  2 Basic: A={4,3,2,1}, B={8,7,6,5}; array model gives done with r={50,43,22,19} -> cycles
//    T+1..T+3 show feed schedule exactly; res_valid=1 with res_data={50,43,22,19}, carries=0.
//  3 Backpressure: res_ready=0 for 10 cycles in HOLD, arr_result toggled -> res_data unchanged,
//    start ignored, ready=0; res_ready=1 -> IDLE next cycle.
//  4 Timeout: TIMEOUT_CYC=8, arr_done never asserted -> timeout_err=1 for exactly 1 cycle,
//    8 cycles after entering WAIT, res_valid never 1, ready=1 afterwards.
//  5 Spurious done: arr_done=1 in IDLE and FEED1 -> no capture, schedule unaltered.
//  6 Back-to-back: start held high continuously, two operand sets -> second accepted only
//    after first result handshake; both results correct, in order.

Source files
------------

// File: rtl/sys_array_seq_ctrl.sv
// Sequencer for the 2x2 systolic matrix-multiply array: feeds skewed operands,
// waits for the array's done, then holds the captured results on a valid/ready port.
module sys_array_seq_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                ready_o,
  input  logic [4*DATA_W-1:0] a_mat_i,
  input  logic [4*DATA_W-1:0] b_mat_i,
  output logic                load_in_o,
  output logic [DATA_W-1:0]   row_in_row0_o,
  output logic [DATA_W-1:0]   row_in_row1_o,
  output logic [DATA_W-1:0]   col_in_col0_o,
  output logic [DATA_W-1:0]   col_in_col1_o,
  input  logic                arr_done_i,
  input  logic [4*64-1:0]     arr_result_i,
  input  logic [3:0]          arr_carry_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [4*64-1:0]     res_data_o,
  output logic [3:0]          res_carry_o,
  output logic                timeout_err_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    FEED0,
    FEED1,
    FEED2,
    WAIT,
    HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // A00/B00 go straight out on the accept edge, so only the later elements are kept
  logic [3*DATA_W-1:0]   a_q, a_d;
  logic [3*DATA_W-1:0]   b_q, b_d;
  logic                  ready_q, ready_d;
  logic                  load_q, load_d;
  logic [DATA_W-1:0]     row0_q, row0_d;
  logic [DATA_W-1:0]     row1_q, row1_d;
  logic [DATA_W-1:0]     col0_q, col0_d;
  logic [DATA_W-1:0]     col1_q, col1_d;
  logic                  res_valid_q, res_valid_d;
  logic [4*64-1:0]       res_data_q, res_data_d;
  logic [3:0]            res_carry_q, res_carry_d;
  logic                  tout_q, tout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ready_q     <= 1'b1;
      load_q      <= 1'b0;
      row0_q      <= '0;
      row1_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ready_q     <= ready_d;
      load_q      <= load_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      tout_q      <= tout_d;
    end
  end

  // Outputs are computed one state ahead so each registered value matches state_q
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    load_d      = 1'b0;
    row0_d      = '0;
    row1_d      = '0;
    col0_d      = '0;
    col1_d      = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    tout_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && ready_q) begin
          a_d     = a_mat_i[4*DATA_W-1:DATA_W];
          b_d     = b_mat_i[4*DATA_W-1:DATA_W];
          load_d  = 1'b1;
          row0_d  = a_mat_i[0 +: DATA_W];
          col0_d  = b_mat_i[0 +: DATA_W];
          state_d = FEED0;
        end
      end
      FEED0: begin
        load_d  = 1'b1;
        row0_d  = a_q[0 +: DATA_W];
        row1_d  = a_q[DATA_W +: DATA_W];
        col0_d  = b_q[DATA_W +: DATA_W];
        col1_d  = b_q[0 +: DATA_W];
        state_d = FEED1;
      end
      FEED1: begin
        load_d  = 1'b1;
        row1_d  = a_q[2*DATA_W +: DATA_W];
        col1_d  = b_q[2*DATA_W +: DATA_W];
        state_d = FEED2;
      end
      FEED2: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (arr_done_i) begin
          res_valid_d = 1'b1;
          res_data_d  = arr_result_i;
          res_carry_d = arr_carry_i;
          state_d     = HOLD;
        end else if (cnt_q == CNT_MAX) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign ready_o       = ready_q;
  assign load_in_o     = load_q;
  assign row_in_row0_o = row0_q;
  assign row_in_row1_o = row1_q;
  assign col_in_col0_o = col0_q;
  assign col_in_col1_o = col1_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_carry_o   = res_carry_q;
  assign timeout_err_o = tout_q;

endmodule

// File: tb/tb_sys_array_seq_ctrl.sv
// Self-checking bench for sys_array_seq_ctrl: plays the host and the array, and
// compares feed schedule, captured results and timeout behaviour against a matrix model.
module tb_sys_array_seq_ctrl;

  localparam int DW  = 32;
  localparam int TMO = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           ready;
  logic [4*DW-1:0] aMat, bMat;
  logic           loadIn;
  logic [DW-1:0]  row0, row1, col0, col1;
  logic           arrDone;
  logic [255:0]   arrResult;
  logic [3:0]     arrCarry;
  logic           resValid;
  logic           resReady;
  logic [255:0]   resData;
  logic [3:0]     resCarry;
  logic           timeoutErr;

  int chkCount = 0;
  int errCount = 0;

  sys_array_seq_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .ready_o      (ready),
    .a_mat_i      (aMat),
    .b_mat_i      (bMat),
    .load_in_o    (loadIn),
    .row_in_row0_o(row0),
    .row_in_row1_o(row1),
    .col_in_col0_o(col0),
    .col_in_col1_o(col1),
    .arr_done_i   (arrDone),
    .arr_result_i (arrResult),
    .arr_carry_i  (arrCarry),
    .res_valid_o  (resValid),
    .res_ready_i  (resReady),
    .res_data_o   (resData),
    .res_carry_o  (resCarry),
    .timeout_err_o(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [4*DW-1:0] randMat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference array: C = A * B over 2x2 matrices, element (i,j) at index 2*i+j, 64-bit wrap
  function automatic logic [255:0] matMul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    logic [63:0]  c [4];
    logic [255:0] packed_c;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c[2*i+j] = 64'(a[(2*i+0)*DW +: DW]) * 64'(b[(0*2+j)*DW +: DW])
                 + 64'(a[(2*i+1)*DW +: DW]) * 64'(b[(1*2+j)*DW +: DW]);
      end
    packed_c = {c[3], c[2], c[1], c[0]};
    return packed_c;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".ready"}, 256'(ready), 256'(1));
    checkOutput({tag, ".load"}, 256'(loadIn), 256'(0));
    checkOutput({tag, ".rows"}, 256'({row0, row1, col0, col1}), 256'(0));
    checkOutput({tag, ".valid"}, 256'(resValid), 256'(0));
    checkOutput({tag, ".tout"}, 256'(timeoutErr), 256'(0));
  endtask

  // Accept one operand set, check the three feed cycles; caller is just after an edge
  task automatic feedPhase(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                           input bit holdStart, input bit spurious);
    logic [DW-1:0] ae [4];
    logic [DW-1:0] be [4];
    logic [DW-1:0] expRow0, expRow1, expCol0, expCol1;
    for (int i = 0; i < 4; i++) begin
      ae[i] = a[i*DW +: DW];
      be[i] = b[i*DW +: DW];
    end
    checkOutput("preReady", 256'(ready), 256'(1));
    start = 1'b1;
    aMat  = a;
    bMat  = b;
    tick();
    if (!holdStart) start = 1'b0;
    aMat = randMat();
    bMat = randMat();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin expRow0 = ae[0]; expRow1 = '0;    expCol0 = be[0]; expCol1 = '0;    end
        1: begin expRow0 = ae[1]; expRow1 = ae[2]; expCol0 = be[2]; expCol1 = be[1]; end
        default: begin expRow0 = '0; expRow1 = ae[3]; expCol0 = '0; expCol1 = be[3]; end
      endcase
      checkOutput($sformatf("feed%0d.load", k), 256'(loadIn), 256'(1));
      checkOutput($sformatf("feed%0d.row0", k), 256'(row0), 256'(expRow0));
      checkOutput($sformatf("feed%0d.row1", k), 256'(row1), 256'(expRow1));
      checkOutput($sformatf("feed%0d.col0", k), 256'(col0), 256'(expCol0));
      checkOutput($sformatf("feed%0d.col1", k), 256'(col1), 256'(expCol1));
      checkOutput($sformatf("feed%0d.ready", k), 256'(ready), 256'(0));
      checkOutput($sformatf("feed%0d.valid", k), 256'(resValid), 256'(0));
      arrDone   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      arrResult = rand256();
      tick();
    end
    checkOutput("wait.load", 256'(loadIn), 256'(0));
    checkOutput("wait.rows", 256'({row0, row1, col0, col1}), 256'(0));
  endtask

  // Full transaction: feed, array answers after doneDelay WAIT cycles, result stalled holdStall cycles
  task automatic applyStimulus(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                               input logic [3:0] carry, input int doneDelay, input int holdStall,
                               input bit holdStart, input bit spurious);
    logic [255:0] expRes;
    expRes = matMul(a, b);
    feedPhase(a, b, holdStart, spurious);
    for (int d = 0; d <= doneDelay; d++) begin
      arrDone   = (d == doneDelay);
      arrResult = (d == doneDelay) ? expRes : rand256();
      arrCarry  = (d == doneDelay) ? carry : 4'($urandom);
      tick();
      if (d < doneDelay) checkOutput("wait.valid", 256'(resValid), 256'(0));
    end
    arrDone   = 1'b0;
    arrResult = rand256();
    arrCarry  = 4'($urandom);
    checkOutput("hold.valid", 256'(resValid), 256'(1));
    checkOutput("hold.data", resData, expRes);
    checkOutput("hold.carry", 256'(resCarry), 256'(carry));
    checkOutput("hold.tout", 256'(timeoutErr), 256'(0));
    for (int s = 0; s < holdStall; s++) begin
      resReady  = 1'b0;
      start     = 1'b1;
      arrDone   = 1'($urandom_range(0, 1));
      arrResult = rand256();
      tick();
      checkOutput("stall.valid", 256'(resValid), 256'(1));
      checkOutput("stall.data", resData, expRes);
      checkOutput("stall.ready", 256'(ready), 256'(0));
    end
    arrDone  = 1'b0;
    start    = holdStart;
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    checkOutput("post.valid", 256'(resValid), 256'(0));
    checkOutput("post.ready", 256'(ready), 256'(1));
  endtask

  task automatic timeoutRun();
    feedPhase(randMat(), randMat(), 1'b0, 1'b0);
    arrDone = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      tick();
      checkOutput($sformatf("tmo.pulse%0d", i), 256'(timeoutErr), 256'(i == TMO));
      checkOutput("tmo.valid", 256'(resValid), 256'(0));
    end
    checkOutput("tmo.ready", 256'(ready), 256'(1));
    tick();
    checkOutput("tmo.pulseEnd", 256'(timeoutErr), 256'(0));
    checkOutput("tmo.readyAfter", 256'(ready), 256'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    aMat      = '0;
    bMat      = '0;
    arrDone   = 1'b0;
    arrResult = '0;
    arrCarry  = '0;
    resReady  = 1'b0;
    #23;
    checkIdleOutputs("reset");
    checkOutput("reset.data", resData, 256'(0));
    checkOutput("reset.carry", 256'(resCarry), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkIdleOutputs("afterReset");

    $display("[TB] basic transaction");
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 4'h0, 0, 0, 1'b0, 1'b0);
    checkOutput("basic.model", matMul({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}),
                {64'd50, 64'd43, 64'd22, 64'd19});

    $display("[TB] backpressure and late done");
    applyStimulus(randMat(), randMat(), 4'hA, 3, 10, 1'b0, 1'b0);
    applyStimulus(randMat(), randMat(), 4'h5, TMO - 1, 1, 1'b0, 1'b0);

    $display("[TB] timeout");
    timeoutRun();

    $display("[TB] spurious done");
    for (int i = 0; i < 3; i++) begin
      arrDone   = 1'b1;
      arrResult = rand256();
      tick();
      checkIdleOutputs("idleDone");
    end
    arrDone = 1'b0;
    applyStimulus(randMat(), randMat(), 4'h3, 2, 0, 1'b0, 1'b1);

    $display("[TB] reset mid-feed");
    start = 1'b1;
    aMat  = randMat();
    bMat  = randMat();
    tick();
    start = 1'b0;
    tick();
    checkOutput("midFeed.load", 256'(loadIn), 256'(1));
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("midReset");
    checkOutput("midReset.data", resData, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkIdleOutputs("afterMidReset");

    $display("[TB] back-to-back");
    applyStimulus(randMat(), randMat(), 4'h9, 1, 2, 1'b1, 1'b0);
    applyStimulus(randMat(), randMat(), 4'h6, 0, 0, 1'b1, 1'b0);
    start = 1'b0;

    $display("[TB] random transactions");
    for (int n = 0; n < 25; n++) begin
      applyStimulus(randMat(), randMat(), 4'($urandom), $urandom_range(0, TMO - 1),
                    $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    timeoutRun();

    $display("Simulation finished: %0d checks, %0d errors", chkCount, errCount);
    $finish;
  end

endmodule
